game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_pkg.sv | 23 ++
 rtl/btn_debounce.sv | 70 +++++++
 rtl/game_ctrl.sv | 152 +++++++++++++++
 tb/tb_game_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : game_pkg                                                       |
// | Purpose  : Shared game definitions: state encoding and datapath widths,   |
// |            used by game_ctrl and by the renderer.                         |
// | Ports    : none (package)                                                 |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package game_pkg;

  typedef enum logic [1:0] {
    GS_IDLE = 2'd0,
    GS_PLAY = 2'd1,
    GS_HIT  = 2'd2,
    GS_OVER = 2'd3
  } game_state_e;

  localparam int TIMER_W = 16;
  localparam int SCORE_W = 4;
  localparam int LIVES_W = 2;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : btn_debounce                                                   |
// | Purpose  : 2-flop synchronizer + tick-based debouncer for a raw button.   |
// |            Emits a one-cycle press pulse on the debounced rising edge.    |
// | Ports    : clk       - system clock                                       |
// |            reset     - asynchronous active-low reset                      |
// |            tick_1ms  - one-cycle millisecond strobe                       |
// |            btn_raw   - raw asynchronous button, active-high               |
// |            press     - registered one-cycle press pulse                   |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module btn_debounce
  import game_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_1ms,
  input  logic btn_raw,
  output logic press
);

  localparam logic [TIMER_W-1:0] CNT_LAST = TIMER_W'(DEBOUNCE_MS - 1);

  logic               sync1_q, sync2_q;
  logic               level_q, level_d;
  logic               press_q, press_d;
  logic [TIMER_W-1:0] cnt_q,   cnt_d;

  // The count only advances while the synchronized input disagrees with the
  // accepted level; a single agreeing cycle restarts it from zero.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (tick_1ms) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        cnt_d   = '0;
        press_d = sync2_q;  // only a 0->1 acceptance is a press
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;

endmodule
`default_nettype wire

// File: rtl/game_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : game_ctrl                                                      |
// | Purpose  : Game state machine: start/play/hit/over sequencing, score,     |
// |            lives and hit-freeze timer.                                    |
// | Ports    : clk, reset (async active-low), tick_1ms strobe                 |
// |            button_start  - raw start button                               |
// |            player_dead   - collision indication                           |
// |            enemy_passed  - enemy escaped pulse (scores a point)           |
// |            game_state    - IDLE/PLAY/HIT/OVER                             |
// |            p1_score, lives, freeze, enemy_respawn, win, led               |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module game_ctrl
  import game_pkg::*;
#(
  parameter int LIVES_INIT  = 3,
  parameter int WIN_SCORE   = 9,
  parameter int HIT_MS      = 1000,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_1ms,
  input  logic               button_start,
  input  logic               player_dead,
  input  logic               enemy_passed,
  output logic [1:0]         game_state,
  output logic [SCORE_W-1:0] p1_score,
  output logic [LIVES_W-1:0] lives,
  output logic               freeze,
  output logic               enemy_respawn,
  output logic               win,
  output logic               led
);

  localparam logic [LIVES_W-1:0] LIVES_C  = LIVES_W'(LIVES_INIT);
  localparam logic [SCORE_W-1:0] WIN_C    = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] WIN_M1   = SCORE_W'(WIN_SCORE - 1);
  localparam logic [TIMER_W-1:0] HIT_LAST = TIMER_W'(HIT_MS - 1);

  logic               press;
  game_state_e        state_q,   state_d;
  logic [SCORE_W-1:0] score_q,   score_d;
  logic [LIVES_W-1:0] lives_q,   lives_d;
  logic [TIMER_W-1:0] timer_q,   timer_d;
  logic               win_q,     win_d;
  logic               freeze_q,  freeze_d;
  logic               respawn_q, respawn_d;

  btn_debounce #(
    .DEBOUNCE_MS (DEBOUNCE_MS)
  ) u_start_btn (
    .clk      (clk),
    .reset    (reset),
    .tick_1ms (tick_1ms),
    .btn_raw  (button_start),
    .press    (press)
  );

  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    lives_d   = lives_q;
    timer_d   = timer_q;
    win_d     = win_q;
    respawn_d = 1'b0;
    case (state_q)
      GS_IDLE: begin
        if (press) begin
          state_d   = GS_PLAY;
          lives_d   = LIVES_C;
          score_d   = '0;
          win_d     = 1'b0;
          respawn_d = 1'b1;
        end
      end
      GS_PLAY: begin
        // A collision wins over a simultaneous escape: no point is scored.
        if (player_dead) begin
          state_d = GS_HIT;
          lives_d = (lives_q != '0) ? lives_q - 2'd1 : '0;
          timer_d = '0;
        end else if (enemy_passed) begin
          // Saturating compare keeps the score from ever passing WIN_SCORE.
          if (score_q >= WIN_M1) begin
            score_d = WIN_C;
            state_d = GS_OVER;
            win_d   = 1'b1;
          end else begin
            score_d = score_q + 4'd1;
          end
        end
      end
      GS_HIT: begin
        if (tick_1ms) begin
          if (timer_q == HIT_LAST) begin
            timer_d = '0;
            if (lives_q == '0) begin
              state_d = GS_OVER;
              win_d   = 1'b0;
            end else begin
              state_d   = GS_PLAY;
              respawn_d = 1'b1;
            end
          end else begin
            timer_d = timer_q + 16'd1;
          end
        end
      end
      GS_OVER: begin
        if (press) begin
          state_d = GS_IDLE;
        end
      end
      default: state_d = GS_IDLE;
    endcase
    // Motion runs only while playing; derived from the next state so that
    // freeze changes in the same cycle as game_state.
    freeze_d = (state_d != GS_PLAY);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= GS_IDLE;
      score_q   <= '0;
      lives_q   <= '0;
      timer_q   <= '0;
      win_q     <= 1'b0;
      freeze_q  <= 1'b1;
      respawn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      score_q   <= score_d;
      lives_q   <= lives_d;
      timer_q   <= timer_d;
      win_q     <= win_d;
      freeze_q  <= freeze_d;
      respawn_q <= respawn_d;
    end
  end

  assign game_state    = state_q;
  assign p1_score      = score_q;
  assign lives         = lives_q;
  assign freeze        = freeze_q;
  assign enemy_respawn = respawn_q;
  assign win           = win_q;
  assign led           = freeze_q;

endmodule
`default_nettype wire

// File: tb/tb_game_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_game_ctrl                                                   |
// | Purpose  : Self-checking bench for game_ctrl: directed game scenarios     |
// |            followed by randomized play, against a behavioural model.      |
// | Ports    : none                                                           |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_game_ctrl;

  localparam int DB = 2;   // debounce ticks
  localparam int HM = 5;   // hit freeze ticks
  localparam int LI = 3;   // initial lives
  localparam int WS = 9;   // winning score
  localparam int TP = 4;   // clocks per tick_1ms

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_1ms;
  logic       button_start;
  logic       player_dead;
  logic       enemy_passed;
  logic [1:0] game_state;
  logic [3:0] p1_score;
  logic [1:0] lives;
  logic       freeze;
  logic       enemy_respawn;
  logic       win;
  logic       led;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_tick = 0;
  int resp_cnt = 0;

  // Behavioural model state (0=IDLE 1=PLAY 2=HIT 3=OVER)
  int m_state, m_score, m_lives, m_ticks_in_hit, m_disagree;
  bit m_win, m_freeze, m_resp, m_press;
  bit m_s1, m_s2, m_level;

  game_ctrl #(
    .LIVES_INIT  (LI),
    .WIN_SCORE   (WS),
    .HIT_MS      (HM),
    .DEBOUNCE_MS (DB)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .tick_1ms      (tick_1ms),
    .button_start  (button_start),
    .player_dead   (player_dead),
    .enemy_passed  (enemy_passed),
    .game_state    (game_state),
    .p1_score      (p1_score),
    .lives         (lives),
    .freeze        (freeze),
    .enemy_respawn (enemy_respawn),
    .win           (win),
    .led           (led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_score = 0; m_lives = 0; m_ticks_in_hit = 0;
    m_win = 0; m_freeze = 1; m_resp = 0; m_press = 0;
    m_s1 = 0; m_s2 = 0; m_level = 0; m_disagree = 0;
  endtask

  // One clock edge of game behaviour, from the rules of the game.
  task automatic model_step(input bit b, input bit t, input bit pd, input bit ep);
    bit p;
    bit new_press;
    p = m_press;
    new_press = 0;
    m_resp = 0;
    case (m_state)
      0: if (p) begin
           m_state = 1; m_lives = LI; m_score = 0; m_win = 0; m_resp = 1;
         end
      1: if (pd) begin
           m_state = 2; m_lives = (m_lives > 0) ? m_lives - 1 : 0; m_ticks_in_hit = 0;
         end else if (ep) begin
           m_score = m_score + 1;
           if (m_score >= WS) begin m_score = WS; m_state = 3; m_win = 1; end
         end
      2: if (t) begin
           m_ticks_in_hit++;
           if (m_ticks_in_hit == HM) begin
             if (m_lives == 0) begin m_state = 3; m_win = 0; end
             else begin m_state = 1; m_resp = 1; end
           end
         end
      default: if (p) m_state = 0;
    endcase
    m_freeze = (m_state != 1);
    // Button: two cycles of synchronizer delay, then DB disagreeing ticks.
    if (m_s2 == m_level) m_disagree = 0;
    else if (t) begin
      m_disagree++;
      if (m_disagree == DB) begin
        m_level = m_s2; m_disagree = 0; new_press = m_s2;
      end
    end
    m_s2 = m_s1;
    m_s1 = b;
    m_press = new_press;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_state"},   int'(game_state),    m_state);
    chk({tag, "_score"},   int'(p1_score),      m_score);
    chk({tag, "_lives"},   int'(lives),         m_lives);
    chk({tag, "_freeze"},  int'(freeze),        int'(m_freeze));
    chk({tag, "_win"},     int'(win),           int'(m_win));
    chk({tag, "_respawn"}, int'(enemy_respawn), int'(m_resp));
    chk({tag, "_led"},     int'(led),           int'(m_freeze));
  endtask

  task automatic cycle(input bit b, input bit pd, input bit ep);
    @(negedge clk);
    button_start = b;
    player_dead  = pd;
    enemy_passed = ep;
    tick_1ms     = (cyc_tick == TP - 1);
    cyc_tick     = (cyc_tick + 1) % TP;
    model_step(b, tick_1ms, pd, ep);
    @(posedge clk);
    #1;
    compare_all("cyc");
    if (enemy_respawn) resp_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0);
  endtask

  task automatic press_btn();
    for (int i = 0; i < 3 * TP + 4; i++) cycle(1, 0, 0);
    idle(3 * TP + 4);
  endtask

  // Reset asserted away from any clock edge: outputs must change at once.
  task automatic do_reset();
    @(negedge clk);
    tick_1ms = 0; button_start = 0; player_dead = 0; enemy_passed = 0;
    #2;
    reset = 0;
    #1;
    model_reset();
    compare_all("rst");
    repeat (2) @(negedge clk);
    reset = 1;
  endtask

  initial begin
    bit rb;
    reset = 1; tick_1ms = 0; button_start = 0; player_dead = 0; enemy_passed = 0;
    model_reset();
    #2;
    reset = 0;
    #1;
    compare_all("por");
    chk("por_led", int'(led), 1);
    repeat (2) @(negedge clk);
    reset = 1;
    idle(5);

    // Glitch: synchronized button high across exactly one tick
    for (int i = 0; i < TP; i++) cycle(1, 0, 0);
    idle(12);
    chk("glitch_state", int'(game_state), 0);

    // Proper press starts the game
    resp_cnt = 0;
    press_btn();
    chk("start_state", int'(game_state), 1);
    chk("start_lives", int'(lives), 3);
    chk("start_score", int'(p1_score), 0);
    chk("start_respawn_cnt", resp_cnt, 1);

    // Score 4, then collision and escape together
    for (int i = 0; i < 4; i++) begin cycle(0, 0, 1); cycle(0, 0, 0); end
    cycle(0, 1, 1);
    chk("hit_state", int'(game_state), 2);
    chk("hit_lives", int'(lives), 2);
    chk("hit_score", int'(p1_score), 4);
    resp_cnt = 0;
    idle(HM * TP + 4);
    chk("hit_ret_state", int'(game_state), 1);
    chk("hit_ret_respawn_cnt", resp_cnt, 1);

    // Two more hits exhaust the lives
    for (int h = 0; h < 2; h++) begin
      cycle(0, 1, 0);
      idle(HM * TP + 4);
    end
    chk("lose_state", int'(game_state), 3);
    chk("lose_win", int'(win), 0);
    chk("lose_lives", int'(lives), 0);
    for (int i = 0; i < 3; i++) begin cycle(0, 0, 1); cycle(0, 0, 0); end
    chk("over_score_held", int'(p1_score), 4);

    // Back to IDLE, new game, win on score
    press_btn();
    chk("over_to_idle", int'(game_state), 0);
    press_btn();
    for (int i = 0; i < WS; i++) begin cycle(0, 0, 1); cycle(0, 0, 0); end
    chk("win_score", int'(p1_score), 9);
    chk("win_state", int'(game_state), 3);
    chk("win_flag", int'(win), 1);
    chk("win_freeze", int'(freeze), 1);
    press_btn();
    chk("win_to_idle", int'(game_state), 0);

    // Reset in the middle of a hit freeze
    press_btn();
    cycle(0, 1, 0);
    idle(6);
    do_reset();
    chk("midrst_state", int'(game_state), 0);
    chk("midrst_score", int'(p1_score), 0);
    chk("midrst_lives", int'(lives), 0);
    chk("midrst_freeze", int'(freeze), 1);
    idle(30);
    chk("midrst_stay_idle", int'(game_state), 0);

    // Randomized play
    rb = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 11) == 0) rb = ~rb;
      cycle(rb, $urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0);
      if ($urandom_range(0, 1499) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
